uart_link_arbiter: RTL and testbench

- Shares one UART link (32-bit TX frame, 16-bit RX word) between NUM_REQ bus-bridge requesters, e.g. several bus_bridge_slave instances or bridge-side masters.
- Arbitrates round-robin at frame granularity and owns the UART data_en/data_input handshake.
- For read frames, holds the link until the returning RX word arrives or a timeout expires, then routes the word to the issuing requester.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_link_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_link_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the UART bridge slice: link FSM encoding, default widths
// and the field layout of a 32-bit bridge frame.
package bridge_pkg;

    localparam int FRAME_WIDTH_DEF = 32;
    localparam int RX_WIDTH_DEF    = 16;

    // Frame layout: addr [11:0], marker [13:12], data [21:14], mode [22]
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_W     = 12;
    localparam int MARKER_LSB = 12;
    localparam int MARKER_W   = 2;
    localparam int DATA_LSB   = 14;
    localparam int DATA_W     = 8;
    localparam int MODE_BIT   = 22;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_TX_START  = 3'd2,
        ST_TX_DRAIN  = 3'd3,
        ST_WAIT_RESP = 3'd4
    } link_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after rr_ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] slot;

    // Walk offsets from the far end down so the nearest requester overwrites last.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        slot      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = {1'b0, rr_ptr} + SW'(i);
            if (slot >= SW'(NUM_REQ)) begin
                slot = slot - SW'(NUM_REQ);
            end
            if (req[slot[IDX_W-1:0]]) begin
                grant     = slot[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_link_arbiter.sv
// Shares one UART link between NUM_REQ requesters, one frame at a time, and routes
// read responses (or timeouts) back to the requester that issued the read.
module uart_link_arbiter
    import bridge_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int FRAME_WIDTH    = FRAME_WIDTH_DEF,
    parameter int RX_WIDTH       = RX_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_frame,
    input  logic [NUM_REQ-1:0]             req_expect_resp,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [NUM_REQ-1:0]             resp_timeout,
    output logic [RX_WIDTH-1:0]            resp_data,
    output logic                           link_busy,
    output logic [FRAME_WIDTH-1:0]         u_din,
    output logic                           u_en,
    input  logic                           u_tx_busy,
    input  logic                           u_rx_ready,
    input  logic [RX_WIDTH-1:0]            u_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    link_state_t state;
    link_state_t state_next;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       ptr_next;
    logic                   any_valid;
    logic                   expect_resp_q;
    logic [TO_W-1:0]        to_cnt;
    logic [NUM_REQ-1:0]     owner_onehot;
    logic [FRAME_WIDTH-1:0] grant_frame;
    logic                   grant_expect;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        owner_onehot = '0;
        grant_frame  = '0;
        grant_expect = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_onehot[i] = (owner == IDX_W'(i));
            if (grant == IDX_W'(i)) begin
                grant_frame  = req_frame[i*FRAME_WIDTH +: FRAME_WIDTH];
                grant_expect = req_expect_resp[i];
            end
        end
    end

    assign ptr_next = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            expect_resp_q <= 1'b0;
            to_cnt        <= '0;
            u_din         <= '0;
            resp_data     <= '0;
            resp_valid    <= '0;
            resp_timeout  <= '0;
        end else begin
            state        <= state_next;
            resp_valid   <= '0;
            resp_timeout <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner         <= grant;
                        u_din         <= grant_frame;
                        expect_resp_q <= grant_expect;
                    end
                end
                ST_LAUNCH: begin
                    rr_ptr <= ptr_next;
                end
                // Data beats the timeout when both land on the same cycle.
                ST_WAIT_RESP: begin
                    if (u_rx_ready) begin
                        resp_data  <= u_dout;
                        resp_valid <= owner_onehot;
                        to_cnt     <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        resp_timeout <= owner_onehot;
                        to_cnt       <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        u_en       = 1'b0;
        req_ack    = '0;
        link_busy  = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                u_en       = 1'b1;
                req_ack    = owner_onehot;
                state_next = ST_TX_START;
            end
            ST_TX_START: begin
                if (u_tx_busy) begin
                    state_next = ST_TX_DRAIN;
                end
            end
            ST_TX_DRAIN: begin
                if (!u_tx_busy) begin
                    state_next = expect_resp_q ? ST_WAIT_RESP : ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (u_rx_ready || (to_cnt == TO_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_link_arbiter.sv
// Scoreboard bench for uart_link_arbiter: directed frames against a small UART busy model,
// with expected acks/responses queued by the stimulus and checked by a negedge monitor.
module tb_uart_link_arbiter;

    localparam int NUM_REQ = 2;
    localparam int FW      = 32;
    localparam int RW      = 16;
    localparam int TO      = 16;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*FW-1:0] req_frame;
    logic [NUM_REQ-1:0]    req_expect_resp;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_timeout;
    logic [RW-1:0]         resp_data;
    logic                  link_busy;
    logic [FW-1:0]         u_din;
    logic                  u_en;
    logic                  u_tx_busy;
    logic                  u_rx_ready;
    logic [RW-1:0]         u_dout;

    typedef struct {
        int          id;
        logic [31:0] frame;
    } ack_exp_t;

    typedef struct {
        bit          is_timeout;
        int          id;
        logic [15:0] data;
    } resp_exp_t;

    ack_exp_t  ack_q[$];
    resp_exp_t resp_q[$];
    ack_exp_t  mon_ack;
    resp_exp_t mon_resp;

    int checks = 0;
    int errors = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    int n;

    uart_link_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .FRAME_WIDTH    (FW),
        .RX_WIDTH       (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_frame       (req_frame),
        .req_expect_resp (req_expect_resp),
        .req_ack         (req_ack),
        .resp_valid      (resp_valid),
        .resp_timeout    (resp_timeout),
        .resp_data       (resp_data),
        .link_busy       (link_busy),
        .u_din           (u_din),
        .u_en            (u_en),
        .u_tx_busy       (u_tx_busy),
        .u_rx_ready      (u_rx_ready),
        .u_dout          (u_dout)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: busy rises the cycle after data_en and lasts busy_len cycles.
    always @(posedge clk) begin
        if (!rstn) begin
            busy_cnt <= 0;
        end else if (u_en) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign u_tx_busy = (busy_cnt != 0);

    function automatic logic [1:0] onehot(input int id);
        logic [1:0] one;
        one = 2'b01;
        return one << id;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_expired(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=no event required=event within bound", name);
    endtask

    task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] expect_resp,
                                  input logic [31:0] frame0, input logic [31:0] frame1);
        req_valid       = valid;
        req_expect_resp = expect_resp;
        req_frame       = {frame1, frame0};
    endtask

    task automatic wait_ack(input int idx, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!req_ack[idx] && cycles < 40);
        if (!req_ack[idx]) report_expired("wait_ack");
    endtask

    task automatic wait_any_ack(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (req_ack == 2'b00 && cycles < 40);
        if (req_ack == 2'b00) report_expired("wait_any_ack");
    endtask

    // Returns at the first negedge where busy has fallen again.
    task automatic wait_tx();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!u_tx_busy && c < 40);
        if (!u_tx_busy) report_expired("wait_busy_rise");
        c = 0;
        while (u_tx_busy && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (u_tx_busy) report_expired("wait_busy_fall");
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (link_busy && c < 100);
        if (link_busy) report_expired("wait_idle");
    endtask

    // Monitor: any ack or response pulse must match the head of its queue.
    always @(negedge clk) begin
        if (u_en || req_ack != 2'b00) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack actual req_ack=%b u_en=%b required none",
                         req_ack, u_en);
            end else begin
                mon_ack = ack_q.pop_front();
                check_output("ack_owner", 32'(req_ack), 32'(onehot(mon_ack.id)));
                check_output("ack_u_en", 32'(u_en), 32'd1);
                check_output("ack_u_din", u_din, mon_ack.frame);
            end
        end
        if (resp_valid != 2'b00 || resp_timeout != 2'b00) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp actual valid=%b timeout=%b required none",
                         resp_valid, resp_timeout);
            end else begin
                mon_resp = resp_q.pop_front();
                if (mon_resp.is_timeout) begin
                    check_output("resp_timeout_owner", 32'(resp_timeout), 32'(onehot(mon_resp.id)));
                    check_output("resp_timeout_no_valid", 32'(resp_valid), 32'd0);
                end else begin
                    check_output("resp_valid_owner", 32'(resp_valid), 32'(onehot(mon_resp.id)));
                    check_output("resp_valid_no_timeout", 32'(resp_timeout), 32'd0);
                    check_output("resp_data", 32'(resp_data), 32'(mon_resp.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(2'b00, 2'b00, 32'h0, 32'h0);
        u_rx_ready = 1'b0;
        u_dout     = '0;
        rstn       = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_link_busy", 32'(link_busy), 32'd0);
        check_output("reset_u_en", 32'(u_en), 32'd0);
        check_output("reset_u_din", u_din, 32'd0);
        check_output("reset_req_ack", 32'(req_ack), 32'd0);
        check_output("reset_resp_data", 32'(resp_data), 32'd0);
        rstn = 1'b1;

        $display("[TB] single write on port 0");
        busy_len = 10;
        apply_stimulus(2'b01, 2'b00, 32'h0040_2A05, 32'h0);
        ack_q.push_back('{id: 0, frame: 32'h0040_2A05});
        wait_ack(0, n);
        check_output("write_ack_latency", n, 32'd1);
        req_valid = 2'b00;
        wait_tx();
        check_output("write_drain_hold", 32'(link_busy), 32'd1);
        @(negedge clk);
        check_output("write_idle", 32'(link_busy), 32'd0);
        check_output("u_din_held", u_din, 32'h0040_2A05);

        $display("[TB] read round trip on port 1");
        busy_len = 4;
        apply_stimulus(2'b10, 2'b10, 32'h0, 32'h8052_3456);
        ack_q.push_back('{id: 1, frame: 32'h8052_3456});
        resp_q.push_back('{is_timeout: 1'b0, id: 1, data: 16'h00C3});
        wait_ack(1, n);
        check_output("read_ack_latency", n, 32'd1);
        req_valid = 2'b00;
        wait_tx();
        repeat (3) @(negedge clk);
        u_rx_ready = 1'b1;
        u_dout     = 16'h00C3;
        @(negedge clk);
        u_rx_ready = 1'b0;
        check_output("read_resp_valid", 32'(resp_valid), 32'h2);
        check_output("read_resp_data", 32'(resp_data), 32'h00C3);
        check_output("read_link_free", 32'(link_busy), 32'd0);
        @(negedge clk);
        check_output("read_resp_pulse_end", 32'(resp_valid), 32'd0);

        $display("[TB] round robin with both ports valid");
        busy_len = 3;
        apply_stimulus(2'b11, 2'b00, 32'h1111_0001, 32'h2222_0002);
        ack_q.push_back('{id: 0, frame: 32'h1111_0001});
        ack_q.push_back('{id: 1, frame: 32'h2222_0002});
        ack_q.push_back('{id: 0, frame: 32'h1111_0001});
        ack_q.push_back('{id: 1, frame: 32'h2222_0002});
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(n);
            check_output("rr_grant", 32'(req_ack), 32'(onehot(k % 2)));
        end
        req_valid = 2'b00;
        wait_idle();

        $display("[TB] read timeout on port 0 with port 1 pending");
        busy_len = 3;
        apply_stimulus(2'b11, 2'b01, 32'h0040_0001, 32'h3333_0003);
        ack_q.push_back('{id: 0, frame: 32'h0040_0001});
        resp_q.push_back('{is_timeout: 1'b1, id: 0, data: 16'h0});
        ack_q.push_back('{id: 1, frame: 32'h3333_0003});
        wait_ack(0, n);
        check_output("timeout_read_ack_latency", n, 32'd1);
        req_valid = 2'b10;
        wait_tx();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_timeout == 2'b00 && n < 40);
        // WAIT_RESP is entered on the next edge; the pulse shows 16 cycles after that.
        check_output("timeout_latency", n, 32'd17);
        check_output("timeout_owner", 32'(resp_timeout), 32'h1);
        wait_ack(1, n);
        check_output("pending_granted_after_timeout", n, 32'd1);
        req_valid = 2'b00;
        wait_idle();

        $display("[TB] data on the final timeout cycle, then unsolicited data");
        busy_len = 3;
        apply_stimulus(2'b10, 2'b10, 32'h0, 32'h0040_0002);
        ack_q.push_back('{id: 1, frame: 32'h0040_0002});
        resp_q.push_back('{is_timeout: 1'b0, id: 1, data: 16'h5A5A});
        wait_ack(1, n);
        req_valid = 2'b00;
        wait_tx();
        repeat (16) @(negedge clk);
        u_rx_ready = 1'b1;
        u_dout     = 16'h5A5A;
        @(negedge clk);
        u_rx_ready = 1'b0;
        check_output("coincide_valid", 32'(resp_valid), 32'h2);
        check_output("coincide_no_timeout", 32'(resp_timeout), 32'd0);
        @(negedge clk);
        u_rx_ready = 1'b1;
        u_dout     = 16'hFFFF;
        @(negedge clk);
        u_rx_ready = 1'b0;
        check_output("unsolicited_no_valid", 32'(resp_valid), 32'd0);
        check_output("unsolicited_link_idle", 32'(link_busy), 32'd0);
        @(negedge clk);
        check_output("unsolicited_data_dropped", 32'(resp_data), 32'h5A5A);

        $display("[TB] reset during TX_DRAIN of a read");
        busy_len = 6;
        apply_stimulus(2'b01, 2'b01, 32'h0040_0003, 32'h0);
        ack_q.push_back('{id: 0, frame: 32'h0040_0003});
        wait_ack(0, n);
        req_valid = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_tx_busy && n < 40);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_output("midreset_link_busy", 32'(link_busy), 32'd0);
        check_output("midreset_u_en", 32'(u_en), 32'd0);
        check_output("midreset_u_din", u_din, 32'd0);
        check_output("midreset_resp_data", 32'(resp_data), 32'd0);
        check_output("midreset_resp_flags", 32'({resp_valid, resp_timeout, req_ack}), 32'd0);
        repeat (2) @(negedge clk);
        u_rx_ready = 1'b1;
        u_dout     = 16'h1234;
        @(negedge clk);
        u_rx_ready = 1'b0;
        check_output("rx_after_reset_ignored", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check_output("rx_after_reset_data", 32'(resp_data), 32'd0);

        check_output("ack_queue_drained", ack_q.size(), 32'd0);
        check_output("resp_queue_drained", resp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
